// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle MIPS core: reset hold, run FSM, cycle budget and halt detection.
// Optional PC trace buffer is built when RUN_CTRL_TRACE_EN is defined.
module cpu_run_ctrl #(
  parameter int unsigned RST_CYCLES  = 1,
  parameter int unsigned MAX_CYCLES  = 40,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned PC_W        = 32,
  parameter logic [PC_W-1:0] END_PC  = {PC_W{1'b1}},
  parameter int unsigned LOOP_CYCLES = 4,
  parameter int unsigned TRACE_DEPTH = 8,
  localparam int unsigned IDX_W      = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             halt_in,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_reset,
  output logic             cpu_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  input  logic [IDX_W-1:0] trace_idx,
  output logic [PC_W-1:0]  trace_pc
);

  localparam int unsigned HOLD_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned SAME_W  = 32;
  localparam logic        TO_EN   = (MAX_CYCLES != 0);
  localparam logic        LOOP_EN = (LOOP_CYCLES != 0);
  localparam logic        END_EN  = (END_PC != {PC_W{1'b1}});

  typedef enum logic [1:0] {ST_HOLD, ST_RUN, ST_HALTED, ST_TIMEOUT} state_e;

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [PC_W-1:0]    prev_pc_q, prev_pc_d;
  logic [SAME_W-1:0]  same_q, same_d, same_nxt;
  logic               pc_valid_q, pc_valid_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               cpu_en_q, cpu_en_d;
  logic               done_q, done_d;
  logic               halted_q, halted_d;
  logic               timeout_q, timeout_d;
  logic               same_hit, loop_hit, end_hit, halt_hit, go_hold;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      cycle_q     <= '0;
      prev_pc_q   <= '0;
      same_q      <= '0;
      pc_valid_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
      cpu_en_q    <= 1'b0;
      done_q      <= 1'b0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cycle_q     <= cycle_d;
      prev_pc_q   <= prev_pc_d;
      same_q      <= same_d;
      pc_valid_q  <= pc_valid_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_en_q    <= cpu_en_d;
      done_q      <= done_d;
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cycle_d    = cycle_q;
    prev_pc_d  = prev_pc_q;
    same_d     = same_q;
    pc_valid_d = pc_valid_q;
    done_d     = done_q;
    halted_d   = halted_q;
    timeout_d  = timeout_q;
    go_hold    = 1'b0;

    // same_nxt is the run length of the current PC minus one, including this cycle
    same_hit = pc_valid_q && (pc == prev_pc_q);
    same_nxt = '0;
    if (same_hit) begin
      same_nxt = (same_q == {SAME_W{1'b1}}) ? same_q : same_q + SAME_W'(1);
    end
    loop_hit = LOOP_EN && same_hit && (same_nxt == SAME_W'(LOOP_CYCLES - 1));
    end_hit  = END_EN && (pc == END_PC);
    halt_hit = halt_in || end_hit || loop_hit;

    case (state_q)
      ST_HOLD: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (restart) begin
          go_hold = 1'b1;
        end else begin
          cycle_d    = (cycle_q == {CNT_W{1'b1}}) ? cycle_q : cycle_q + CNT_W'(1);
          prev_pc_d  = pc;
          pc_valid_d = 1'b1;
          same_d     = same_nxt;
          if (halt_hit) begin
            state_d  = ST_HALTED;
            done_d   = 1'b1;
            halted_d = 1'b1;
          end else if (TO_EN && (cycle_q == CNT_W'(MAX_CYCLES - 1))) begin
            state_d   = ST_TIMEOUT;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end
        end
      end
      ST_HALTED, ST_TIMEOUT: begin
        go_hold = restart;
      end
      default: begin
        go_hold = 1'b1;
      end
    endcase

    if (go_hold) begin
      state_d    = ST_HOLD;
      hold_cnt_d = '0;
      cycle_d    = '0;
      same_d     = '0;
      pc_valid_d = 1'b0;
      done_d     = 1'b0;
      halted_d   = 1'b0;
      timeout_d  = 1'b0;
    end

    cpu_reset_d = (state_d == ST_HOLD);
    cpu_en_d    = (state_d == ST_RUN);
  end

  assign cpu_reset   = cpu_reset_q;
  assign cpu_en      = cpu_en_q;
  assign cycle_count = cycle_q;
  assign done        = done_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;

`ifdef RUN_CTRL_TRACE_EN
  logic [PC_W-1:0]  trace_q [TRACE_DEPTH];
  logic [IDX_W-1:0] wptr_q;
  logic [IDX_W-1:0] rd_idx;
  logic             trace_wr;

  assign trace_wr = (state_q == ST_RUN) && !restart;

  // Circular PC capture; oldest entry is overwritten once the pointer wraps
  always_ff @(posedge clk) begin
    if (!reset || go_hold) begin
      wptr_q <= '0;
      for (int i = 0; i < int'(TRACE_DEPTH); i++) begin
        trace_q[i] <= '0;
      end
    end else if (trace_wr) begin
      trace_q[wptr_q] <= pc;
      wptr_q          <= wptr_q + IDX_W'(1);
    end
  end

  assign rd_idx   = wptr_q - IDX_W'(1) - trace_idx;
  assign trace_pc = trace_q[rd_idx];
`else
  logic unused_trace_idx;

  assign unused_trace_idx = ^trace_idx;
  assign trace_pc         = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: default instance plus a MAX_CYCLES=5 / END_PC=0x100 instance.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        reset, restart, halt_in;
  logic [31:0] pc;
  logic [2:0]  trace_idx;

  logic        cpu_reset, cpu_en, done, halted, timeout;
  logic [31:0] cycle_count, trace_pc;
  logic        unused_cpu_reset_b, cpu_en_b, done_b, halted_b, timeout_b;
  logic [31:0] cycle_count_b, unused_trace_pc_b;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cpu_run_ctrl dut (
    .clk(clk), .reset(reset), .restart(restart), .halt_in(halt_in), .pc(pc),
    .cpu_reset(cpu_reset), .cpu_en(cpu_en), .cycle_count(cycle_count),
    .done(done), .halted(halted), .timeout(timeout),
    .trace_idx(trace_idx), .trace_pc(trace_pc)
  );

  cpu_run_ctrl #(.MAX_CYCLES(5), .END_PC(32'h0000_0100)) dut_b (
    .clk(clk), .reset(reset), .restart(restart), .halt_in(halt_in), .pc(pc),
    .cpu_reset(unused_cpu_reset_b), .cpu_en(cpu_en_b), .cycle_count(cycle_count_b),
    .done(done_b), .halted(halted_b), .timeout(timeout_b),
    .trace_idx(trace_idx), .trace_pc(unused_trace_pc_b)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0; restart = 1'b0; halt_in = 1'b0; pc = '0; trace_idx = '0;
    cyc(); cyc();
  endtask

  task automatic release_run();
    reset = 1'b1;
    cyc();
  endtask

  task automatic run_pcs(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      pc = base + 32'(4 * i);
      cyc();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset: got %0h want 1", cpu_reset); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL rst_cpu_en: got %0h want 0", cpu_en); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL rst_cycle_count: got %0d want 0", cycle_count); end
    checks++; if ({done, halted, timeout} !== 3'b000) begin errors++; $display("FAIL rst_status: got %b want 000", {done, halted, timeout}); end
    checks++; if (trace_pc !== 32'd0) begin errors++; $display("FAIL rst_trace_pc: got %0h want 0", trace_pc); end
    release_run();
    checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL rel_cpu_reset: got %0h want 0", cpu_reset); end
    checks++; if (cpu_en !== 1'b1) begin errors++; $display("FAIL rel_cpu_en: got %0h want 1", cpu_en); end
  endtask

  task automatic test_timeout();
    run_pcs(39, 32'h0);
    checks++; if (cycle_count !== 32'd39) begin errors++; $display("FAIL to_pre_count: got %0d want 39", cycle_count); end
    checks++; if (cpu_en !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL to_pre_state: got en=%0h done=%0h want en=1 done=0", cpu_en, done); end
    run_pcs(1, 32'd156);
    checks++; if (timeout !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL to_flag: got to=%0h done=%0h want 1 1", timeout, done); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL to_halted: got %0h want 0", halted); end
    checks++; if (cycle_count !== 32'd40) begin errors++; $display("FAIL to_count: got %0d want 40", cycle_count); end
    checks++; if (cpu_en !== 1'b0 || cpu_reset !== 1'b0) begin errors++; $display("FAIL to_core: got en=%0h rst=%0h want 0 0", cpu_en, cpu_reset); end
    halt_in = 1'b1;
    cyc(); cyc(); cyc();
    halt_in = 1'b0;
    checks++; if (halted !== 1'b0 || timeout !== 1'b1 || cycle_count !== 32'd40) begin
      errors++; $display("FAIL to_hold: got h=%0h to=%0h cnt=%0d want 0 1 40", halted, timeout, cycle_count);
    end
  endtask

  task automatic test_halt();
    apply_reset();
    release_run();
    run_pcs(9, 32'h0);
    pc = 32'h24; halt_in = 1'b1;
    cyc();
    halt_in = 1'b0;
    checks++; if (done !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got done=%0h h=%0h want 1 1", done, halted); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL halt_timeout: got %0h want 0", timeout); end
    checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL halt_count: got %0d want 10", cycle_count); end
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL halt_cpu_en: got %0h want 0", cpu_en); end
    for (int i = 0; i < 20; i++) begin
      pc = 32'h1000 + 32'(4 * i);
      halt_in = i[0];
      cyc();
    end
    halt_in = 1'b0;
    checks++; if (cycle_count !== 32'd10 || halted !== 1'b1) begin
      errors++; $display("FAIL halt_hold: got cnt=%0d h=%0h want 10 1", cycle_count, halted);
    end
`ifdef RUN_CTRL_TRACE_EN
    trace_idx = 3'd0; #1;
    checks++; if (trace_pc !== 32'h24) begin errors++; $display("FAIL trace_newest: got %0h want 24", trace_pc); end
    trace_idx = 3'd7; #1;
    checks++; if (trace_pc !== 32'h08) begin errors++; $display("FAIL trace_oldest: got %0h want 8", trace_pc); end
`else
    trace_idx = 3'd5; #1;
    checks++; if (trace_pc !== 32'h0) begin errors++; $display("FAIL trace_off: got %0h want 0", trace_pc); end
`endif
    cyc();
  endtask

  task automatic test_restart();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    checks++; if (cpu_reset !== 1'b1 || cpu_en !== 1'b0) begin errors++; $display("FAIL rs_core: got rst=%0h en=%0h want 1 0", cpu_reset, cpu_en); end
    checks++; if ({done, halted, timeout} !== 3'b000 || cycle_count !== 32'd0) begin
      errors++; $display("FAIL rs_clear: got st=%b cnt=%0d want 000 0", {done, halted, timeout}, cycle_count);
    end
    for (int i = 0; i < 8; i++) begin
      trace_idx = 3'(i); #1;
      checks++; if (trace_pc !== 32'h0) begin errors++; $display("FAIL rs_trace_%0d: got %0h want 0", i, trace_pc); end
    end
    cyc();
    checks++; if (cpu_en !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("FAIL rs_run: got en=%0h rst=%0h want 1 0", cpu_en, cpu_reset); end
  endtask

  task automatic test_self_loop();
    apply_reset();
    release_run();
    pc = 32'h0; cyc();
    pc = 32'h4; cyc();
    pc = 32'h8; cyc(); cyc(); cyc();
    checks++; if (halted !== 1'b0 || cycle_count !== 32'd5) begin
      errors++; $display("FAIL loop_early: got h=%0h cnt=%0d want 0 5", halted, cycle_count);
    end
    cyc();
    checks++; if (halted !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL loop_halt: got h=%0h done=%0h want 1 1", halted, done); end
    checks++; if (cycle_count !== 32'd6) begin errors++; $display("FAIL loop_count: got %0d want 6", cycle_count); end
  endtask

  task automatic test_priority();
    apply_reset();
    release_run();
    run_pcs(4, 32'h0);
    pc = 32'h10; halt_in = 1'b1;
    cyc();
    halt_in = 1'b0;
    checks++; if (halted_b !== 1'b1 || timeout_b !== 1'b0) begin errors++; $display("FAIL prio_halt_vs_to: got h=%0h to=%0h want 1 0", halted_b, timeout_b); end
    checks++; if (done_b !== 1'b1 || cycle_count_b !== 32'd5) begin errors++; $display("FAIL prio_b_count: got done=%0h cnt=%0d want 1 5", done_b, cycle_count_b); end
    apply_reset();
    release_run();
    run_pcs(3, 32'h0);
    restart = 1'b1; halt_in = 1'b1;
    cyc();
    restart = 1'b0; halt_in = 1'b0;
    checks++; if (cpu_reset !== 1'b1 || done !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL prio_restart: got rst=%0h done=%0h h=%0h want 1 0 0", cpu_reset, done, halted);
    end
    checks++; if (cycle_count !== 32'd0 || cpu_en !== 1'b0) begin errors++; $display("FAIL prio_rs_count: got cnt=%0d en=%0h want 0 0", cycle_count, cpu_en); end
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    checks++; if (cpu_en !== 1'b1 || cpu_reset !== 1'b0) begin errors++; $display("FAIL hold_restart: got en=%0h rst=%0h want 1 0", cpu_en, cpu_reset); end
  endtask

  task automatic test_end_pc();
    apply_reset();
    release_run();
    pc = 32'h100;
    cyc();
    checks++; if (halted_b !== 1'b1 || cycle_count_b !== 32'd1 || cpu_en_b !== 1'b0) begin
      errors++; $display("FAIL endpc_b: got h=%0h cnt=%0d en=%0h want 1 1 0", halted_b, cycle_count_b, cpu_en_b);
    end
    checks++; if (done !== 1'b0 || cpu_en !== 1'b1) begin errors++; $display("FAIL endpc_off: got done=%0h en=%0h want 0 1", done, cpu_en); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    release_run();
    run_pcs(6, 32'h0);
    reset = 1'b0; pc = 32'h18;
    cyc();
    checks++; if (cpu_reset !== 1'b1 || cpu_en !== 1'b0 || cycle_count !== 32'd0) begin
      errors++; $display("FAIL mid_core: got rst=%0h en=%0h cnt=%0d want 1 0 0", cpu_reset, cpu_en, cycle_count);
    end
    checks++; if ({done, halted, timeout} !== 3'b000) begin errors++; $display("FAIL mid_status: got %b want 000", {done, halted, timeout}); end
    release_run();
    checks++; if (cpu_en !== 1'b1 || cycle_count !== 32'd0) begin errors++; $display("FAIL mid_rel: got en=%0h cnt=%0d want 1 0", cpu_en, cycle_count); end
    run_pcs(3, 32'h40);
    checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL mid_count: got %0d want 3", cycle_count); end
  endtask

  initial begin
    reset = 1'b0; restart = 1'b0; halt_in = 1'b0; pc = '0; trace_idx = '0;
    test_reset();
    test_timeout();
    test_halt();
    test_restart();
    test_self_loop();
    test_priority();
    test_end_pc();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
